// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ABL op codes, data-out selects and sequencer enums for the 65C02 datapath
package cpu_pkg;
    localparam logic [4:0] ABL_REG = 5'b00000;
    localparam logic [4:0] ABL_PC  = 5'b00110;
    localparam logic [4:0] ABL_AHL = 5'b01010;
    localparam logic [1:0] DO_PCH = 2'b00;
    localparam logic [1:0] DO_PCL = 2'b01;
    localparam logic [1:0] DO_P   = 2'b10;
    // Encoding is sequential so the entry sequence can advance by increment.
    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_PUSH_H, S_PUSH_L, S_PUSH_P, S_VEC_L, S_VEC_H, S_JUMP
    } state_t;
    typedef enum logic [1:0] {K_RES, K_BRK, K_HW} kind_t;
endpackage

// File: rtl/nmi_edge.sv
// nmi_edge: falling-edge detector on nmi_n with a pending flop where a new edge beats the clear
module nmi_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic nmi_n,
    input  logic clr,
    output logic pend
);
    logic prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
            pend <= 1'b0;
        end else begin
            prev <= nmi_n;
            pend <= (prev & ~nmi_n) | (pend & ~clr);
        end
    end
endmodule

// File: rtl/irq_seq.sv
// irq_seq: arbitrates RESET/NMI/BRK/IRQ and drives the 8-state entry sequence up to the vector jump
module irq_seq
    import cpu_pkg::*;
#(
    parameter logic [7:0] VEC_NMI = 8'hFA,
    parameter logic [7:0] VEC_RES = 8'hFC,
    parameter logic [7:0] VEC_IRQ = 8'hFE
) (
    input  logic       clk,
    input  logic       RST_N,
    input  logic       rdy,
    input  logic       sync,
    input  logic       brk_req,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       i_flag,
    output logic       busy,
    output logic       take,
    output logic [4:0] abl_op,
    output logic       abl_ci,
    output logic       ld_ahl,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       reg_sel,
    output logic [7:0] vec_lo,
    output logic [1:0] do_sel,
    output logic       we,
    output logic       sp_dec,
    output logic       b_flag,
    output logic       set_i,
    output logic       clr_d,
    output logic       abh_db
);
    state_t     state, state_nx;
    kind_t      kind, kind_nx;
    logic [7:0] vec_q, vec_sel;
    logic       nmi_pend, nmi_clr, hw_go;

    assign hw_go   = sync & rdy & (nmi_pend | (~irq_n & ~i_flag));
    assign take    = (state == S_IDLE) & hw_go;
    assign busy    = state != S_IDLE;
    // Late vector choice lets an NMI hijack a BRK/IRQ that is still pushing.
    assign vec_sel = kind == K_RES ? VEC_RES : nmi_pend ? VEC_NMI : VEC_IRQ;
    assign nmi_clr = (state == S_VEC_L) & rdy & (vec_sel == VEC_NMI);

    nmi_edge u_nmi (
        .clk   (clk),
        .rst_n (RST_N),
        .nmi_n (nmi_n),
        .clr   (nmi_clr),
        .pend  (nmi_pend)
    );

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_T1;
            kind  <= K_RES;
            vec_q <= VEC_IRQ;
        end else begin
            state <= state_nx;
            kind  <= kind_nx;
            if (state == S_VEC_L && rdy)
                vec_q <= vec_sel;
        end
    end

    always_comb begin
        state_nx = state;
        kind_nx  = kind;
        if (rdy) begin
            if (state != S_IDLE) begin
                state_nx = state_t'(state + 3'd1);
            end else if (hw_go) begin
                state_nx = S_T1;
                kind_nx  = K_HW;
            end else if (brk_req) begin
                state_nx = S_T1;
                kind_nx  = K_BRK;
            end
        end
    end

    always_comb begin
        abl_op  = ABL_REG;
        abl_ci  = 1'b0;
        ld_ahl  = 1'b0;
        ld_pc   = 1'b0;
        inc_pc  = 1'b0;
        reg_sel = 1'b0;
        vec_lo  = vec_q;
        do_sel  = DO_PCH;
        we      = 1'b0;
        sp_dec  = 1'b0;
        b_flag  = 1'b0;
        set_i   = 1'b0;
        clr_d   = 1'b0;
        abh_db  = 1'b0;
        case (state)
            S_T1: begin
                abl_op = ABL_PC;
                ld_pc  = rdy;
                inc_pc = kind == K_BRK;
            end
            S_PUSH_H, S_PUSH_L, S_PUSH_P: begin
                do_sel = state == S_PUSH_H ? DO_PCH : state == S_PUSH_L ? DO_PCL : DO_P;
                sp_dec = rdy;
                we     = rdy & (kind != K_RES);
                b_flag = (state == S_PUSH_P) & (kind == K_BRK);
            end
            S_VEC_L: begin
                reg_sel = 1'b1;
                vec_lo  = vec_sel;
                set_i   = 1'b1;
                clr_d   = 1'b1;
            end
            S_VEC_H: begin
                reg_sel = 1'b1;
                abl_ci  = 1'b1;
                ld_ahl  = rdy;
            end
            S_JUMP: begin
                abl_op = ABL_AHL;
                ld_pc  = rdy;
                abh_db = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_irq_seq.sv
// tb_irq_seq: directed scoreboard bench; stimulus queues expected per-cycle outputs, a negedge monitor compares
module tb_irq_seq;
    localparam int RES = 0, BRK = 1, HW = 2;

    logic clk = 1'b0, RST_N = 1'b0, rdy = 1'b1, sync = 1'b0, brk_req = 1'b0;
    logic nmi_n = 1'b1, irq_n = 1'b1, i_flag = 1'b1;
    logic busy, take, abl_ci, ld_ahl, ld_pc, inc_pc, reg_sel, we, sp_dec, b_flag, set_i, clr_d, abh_db;
    logic [4:0] abl_op;
    logic [7:0] vec_lo;
    logic [1:0] do_sel;
    logic [27:0] act;
    logic [27:0] q[$];
    logic [7:0] last_vec;
    int vecs = 0, fails = 0;

    irq_seq dut (
        .clk(clk), .RST_N(RST_N), .rdy(rdy), .sync(sync), .brk_req(brk_req),
        .nmi_n(nmi_n), .irq_n(irq_n), .i_flag(i_flag), .busy(busy), .take(take),
        .abl_op(abl_op), .abl_ci(abl_ci), .ld_ahl(ld_ahl), .ld_pc(ld_pc), .inc_pc(inc_pc),
        .reg_sel(reg_sel), .vec_lo(vec_lo), .do_sel(do_sel), .we(we), .sp_dec(sp_dec),
        .b_flag(b_flag), .set_i(set_i), .clr_d(clr_d), .abh_db(abh_db)
    );

    always #5 clk = ~clk;

    assign act = {busy, take, abl_op, abl_ci, ld_ahl, ld_pc, inc_pc, reg_sel, vec_lo,
                  do_sel, we, sp_dec, b_flag, set_i, clr_d, abh_db};

    function automatic logic [27:0] rec(input logic bsy, tk, input logic [4:0] op,
        input logic ci, ahl, lpc, ipc, rs, input logic [7:0] v, input logic [1:0] ds,
        input logic w, spd, bf, si, cd, ah);
        return {bsy, tk, op, ci, ahl, lpc, ipc, rs, v, ds, w, spd, bf, si, cd, ah};
    endfunction

    // Expected cycles T1, stalls, PUSH_H..JUMP; only the first n are queued.
    task automatic push_seq(input int k, input logic [7:0] fin, input int stall, input int n);
        logic [27:0] r[$];
        logic w;
        w = (k != RES);
        r.push_back(rec(1, 0, 5'b00110, 0, 0, 1, k == BRK, 0, last_vec, 2'b00, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < stall; i++)
            r.push_back(rec(1, 0, 5'b00000, 0, 0, 0, 0, 0, last_vec, 2'b00, 0, 0, 0, 0, 0, 0));
        r.push_back(rec(1, 0, 5'b00000, 0, 0, 0, 0, 0, last_vec, 2'b00, w, 1, 0, 0, 0, 0));
        r.push_back(rec(1, 0, 5'b00000, 0, 0, 0, 0, 0, last_vec, 2'b01, w, 1, 0, 0, 0, 0));
        r.push_back(rec(1, 0, 5'b00000, 0, 0, 0, 0, 0, last_vec, 2'b10, w, 1, k == BRK, 0, 0, 0));
        r.push_back(rec(1, 0, 5'b00000, 0, 0, 0, 0, 1, fin, 2'b00, 0, 0, 0, 1, 1, 0));
        r.push_back(rec(1, 0, 5'b00000, 1, 1, 0, 0, 1, fin, 2'b00, 0, 0, 0, 0, 0, 0));
        r.push_back(rec(1, 0, 5'b01010, 0, 0, 1, 0, 0, fin, 2'b00, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < n && i < r.size(); i++) q.push_back(r[i]);
        last_vec = fin;
    endtask

    task automatic push_take();
        q.push_back(rec(0, 1, 5'b00000, 0, 0, 0, 0, 0, last_vec, 2'b00, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] a, input logic [7:0] e);
        vecs++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got %h exp %h", name, a, e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) step();
        vecs++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d left exp 0", q.size());
            q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (RST_N && (busy || take)) begin
            vecs++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected got %h exp none", act);
            end else begin
                logic [27:0] e;
                e = q.pop_front();
                if (act !== e) begin
                    fails++;
                    $display("FAIL seq_cycle got %h exp %h", act, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        last_vec = 8'hFE;
        step();
        step();
        chk("rst_busy", {7'd0, busy}, 8'd1);
        chk("rst_op", {3'd0, abl_op}, 8'h06);
        chk("rst_we", {7'd0, we}, 8'd0);
        chk("rst_vec", vec_lo, 8'hFE);
        chk("rst_take", {7'd0, take}, 8'd0);
        // reset sequence
        push_seq(RES, 8'hFC, 0, 7);
        RST_N = 1'b1;
        drain();
        chk("idle_busy", {7'd0, busy}, 8'd0);
        // BRK
        push_seq(BRK, 8'hFE, 0, 7);
        brk_req = 1'b1;
        step();
        brk_req = 1'b0;
        drain();
        // IRQ take, followed by a brk_req that must be suppressed
        push_take();
        sync = 1'b1; irq_n = 1'b0; i_flag = 1'b0;
        push_seq(HW, 8'hFE, 0, 7);
        step();
        sync = 1'b0; irq_n = 1'b1; i_flag = 1'b1; brk_req = 1'b1;
        step();
        brk_req = 1'b0;
        drain();
        // IRQ masked
        sync = 1'b1; irq_n = 1'b0; i_flag = 1'b1;
        #1;
        chk("masked_take", {7'd0, take}, 8'd0);
        step();
        chk("masked_busy", {7'd0, busy}, 8'd0);
        sync = 1'b0; irq_n = 1'b1;
        // NMI hijack of BRK during PUSH_L
        push_seq(BRK, 8'hFA, 0, 7);
        brk_req = 1'b1;
        step();
        brk_req = 1'b0;
        step();
        step();
        nmi_n = 1'b0;
        drain();
        // pending NMI consumed by the hijack
        sync = 1'b1; nmi_n = 1'b1;
        #1;
        chk("nmi_cleared", {7'd0, take}, 8'd0);
        step();
        chk("nmi_cleared_busy", {7'd0, busy}, 8'd0);
        sync = 1'b0;
        // NMI taken from idle
        nmi_n = 1'b0;
        step();
        push_take();
        push_seq(HW, 8'hFA, 0, 7);
        sync = 1'b1;
        step();
        sync = 1'b0; nmi_n = 1'b1;
        drain();
        // rdy stall of 3 cycles in PUSH_H
        push_seq(BRK, 8'hFE, 3, 10);
        brk_req = 1'b1;
        step();
        brk_req = 1'b0;
        step();
        rdy = 1'b0;
        repeat (3) step();
        rdy = 1'b1;
        drain();
        // reset pulse during VEC_H of a BRK
        push_seq(BRK, 8'hFE, 0, 5);
        brk_req = 1'b1;
        step();
        brk_req = 1'b0;
        repeat (5) step();
        RST_N = 1'b0;
        #1;
        chk("abort_ahl", {7'd0, ld_ahl}, 8'd0);
        chk("abort_op", {3'd0, abl_op}, 8'h06);
        chk("abort_busy", {7'd0, busy}, 8'd1);
        chk("abort_vec", vec_lo, 8'hFE);
        step();
        last_vec = 8'hFE;
        push_seq(RES, 8'hFC, 0, 7);
        RST_N = 1'b1;
        drain();
        chk("end_busy", {7'd0, busy}, 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
